serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/full_adder.sv | 14 +
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder.
// State encodings and the default operand width.
package serial_add_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell.
// Purely combinational; used as the serial bit-slice.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);

    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock through one full adder.
// Result and carry-out are published only when the last bit is done.
module serial_adder
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             CO
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             co_q, co_d;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .A  (a_q[0]),
        .B  (b_q[0]),
        .Ci (c_q),
        .S  (fa_s),
        .Co (fa_co)
    );

    // Next-state, datapath shifting and result publishing.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = CI;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_co;
                res_d = {fa_s, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = {fa_s, res_q[WIDTH-1:1]};
                    co_d    = fa_co;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign BUSY = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign DONE = (state_q == S_DONE);
    assign S    = s_q;
    assign CO   = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
// Directed vector table plus hand-written multi-cycle sequences.
module tb_serial_adder;

    logic       CLK;
    logic       RST_N;
    logic       START;
    logic [7:0] A;
    logic [7:0] B;
    logic       CI;
    logic       BUSY;
    logic       DONE;
    logic [7:0] S;
    logic       CO;

    int passed;
    int total;

    serial_adder #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
        .CI    (CI),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .S     (S),
        .CO    (CO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One operation; optional stray START pulse at SHIFT cycle inj_k.
    task automatic run_op(input string nm, input logic [7:0] a,
                          input logic [7:0] b, input logic ci,
                          input logic [7:0] es, input logic eco,
                          input int inj_k);
        int         lat;
        int         busy_n;
        int         done_n;
        logic [7:0] s_prev;
        logic [7:0] s_got;
        logic       co_got;
        logic       chg;
        lat    = -1;
        busy_n = 0;
        done_n = 0;
        s_got  = 8'h00;
        co_got = 1'b0;
        chg    = 1'b0;
        @(negedge CLK);
        START = 1'b1;
        A     = a;
        B     = b;
        CI    = ci;
        @(negedge CLK);
        s_prev = S;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge CLK);
            if (k == 0) begin
                START = 1'b0;
                A     = ~a;
                B     = 8'($urandom);
                CI    = ~ci;
            end
            if (k == inj_k) begin
                START = 1'b1;
                A     = 8'hAA;
                B     = 8'h55;
                CI    = 1'b1;
            end else if (k == inj_k + 1) begin
                START = 1'b0;
            end
            if (BUSY) busy_n++;
            if (DONE) begin
                done_n++;
                if (lat < 0) begin
                    lat    = k;
                    s_got  = S;
                    co_got = CO;
                end
            end else if (lat < 0 && S !== s_prev) begin
                chg = 1'b1;
            end
        end
        START = 1'b0;
        chk({nm, " latency"}, 32'(lat), 32'd8);
        chk({nm, " busy cycles"}, 32'(busy_n), 32'd9);
        chk({nm, " done pulses"}, 32'(done_n), 32'd1);
        chk({nm, " S stable in SHIFT"}, 32'(chg), 32'd0);
        chk({nm, " S"}, 32'(s_got), 32'(es));
        chk({nm, " CO"}, 32'(co_got), 32'(eco));
    endtask

    vec_t       vt[8];
    logic [7:0] ra[40];
    logic [7:0] rb[40];
    logic       rc[40];
    logic [8:0] m;
    logic       bad;
    logic       exp_done;
    int         ndone;

    initial begin
        passed = 0;
        total  = 0;
        RST_N  = 1'b1;
        START  = 1'b0;
        A      = 8'h00;
        B      = 8'h00;
        CI     = 1'b0;

        vt[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vt[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vt[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vt[7] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0};

        // Reset state, with START requested while in reset.
        #2 RST_N = 1'b0;
        START = 1'b1;
        A     = 8'h11;
        B     = 8'h22;
        repeat (3) @(negedge CLK);
        chk("reset BUSY", 32'(BUSY), 32'd0);
        chk("reset DONE", 32'(DONE), 32'd0);
        chk("reset S", 32'(S), 32'd0);
        chk("reset CO", 32'(CO), 32'd0);
        START = 1'b0;
        @(posedge CLK);
        #2 RST_N = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].ci,
                   vt[i].s, vt[i].co, -1);
        end

        // Stray START during SHIFT is ignored.
        run_op("ignore", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 2);

        // Reset in the 4th SHIFT cycle aborts the operation.
        @(negedge CLK);
        START = 1'b1;
        A     = 8'h9C;
        B     = 8'h21;
        CI    = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        chk("abort pre BUSY", 32'(BUSY), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("abort BUSY", 32'(BUSY), 32'd0);
        chk("abort DONE", 32'(DONE), 32'd0);
        chk("abort S", 32'(S), 32'd0);
        chk("abort CO", 32'(CO), 32'd0);
        START = 1'b1;
        bad   = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (BUSY || DONE || S !== 8'h00) bad = 1'b1;
        end
        chk("abort held quiet", 32'(bad), 32'd0);
        START = 1'b0;
        @(posedge CLK);
        #2 RST_N = 1'b1;
        run_op("post reset", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, -1);

        // START held high: new operation every 10 cycles.
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            exp_done = (c == 9) || (c == 19) || (c == 29);
            if (DONE) ndone++;
            chk($sformatf("cont DONE c%0d", c), 32'(DONE), 32'(exp_done));
            if (exp_done) begin
                m = 9'(ra[c-9]) + 9'(rb[c-9]) + 9'(rc[c-9]);
                chk($sformatf("cont S c%0d", c), 32'(S), 32'(m[7:0]));
                chk($sformatf("cont CO c%0d", c), 32'(CO), 32'(m[8]));
            end
            ra[c] = 8'($urandom);
            rb[c] = 8'($urandom);
            rc[c] = 1'($urandom);
            START = (c < 30);
            A     = ra[c];
            B     = rb[c];
            CI    = rc[c];
        end
        chk("cont done count", 32'(ndone), 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
